eight_bit_multiplier: RTL and testbench

Sequential 8x8 unsigned shift-and-add multiplier that sits directly downstream of `eight_bit_adder` and uses it as its only arithmetic resource. Operands are captured on a start handshake, and one partial-product addition runs per clock for 8 clocks. The 16-bit product is then presented with a one-cycle done pulse. This is the first multi-cycle datapath unit in part 1; a later ALU or CPU stage issues operations to it.

---
 rtl/anqa_defs.sv | 14 +
 rtl/eight_bit_adder.sv | 13 +
 rtl/eight_bit_multiplier.sv | 108 ++++++++++
 tb/tb_eight_bit_multiplier.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/anqa_defs.sv
// Shared definitions for the part-1 arithmetic units: FSM encodings and datapath widths.
// No logic; latency and backpressure are properties of the units that import it.
package anqa_defs;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int WORD_BITS = 8;
    localparam int MUL_ITERS = 8;

endpackage

// File: rtl/eight_bit_adder.sv
// 8-bit ripple adder with carry in/out; purely combinational, zero latency.
// No handshake: the sum is valid whenever the inputs are.
module eight_bit_adder (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       CarryIN,
    output logic       CarryOUT,
    output logic [7:0] Sum
);

    assign {CarryOUT, Sum} = {1'b0, A} + {1'b0, B} + {8'b0, CarryIN};

endmodule

// File: rtl/eight_bit_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier; result 8 cycles after the accepting edge.
// Start is only accepted in IDLE or DONE; Start during RUN is dropped, not queued.
module eight_bit_multiplier
    import anqa_defs::*;
(
    input  logic                     Clock,
    input  logic                     ResetN,
    input  logic                     Start,
    input  logic [WORD_BITS-1:0]     A,
    input  logic [WORD_BITS-1:0]     B,
    output logic                     Busy,
    output logic                     Done,
    output logic [2*WORD_BITS-1:0]   Product
);

    state_t                    state_q, state_d;
    logic [WORD_BITS-1:0]      m_q, m_d;
    logic [WORD_BITS-1:0]      q_q, q_d;
    logic [WORD_BITS-1:0]      acc_q, acc_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [2*WORD_BITS-1:0]    prod_q, prod_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      add_c;
    logic [WORD_BITS-1:0]      add_s;
    logic                      pp_c;
    logic [WORD_BITS-1:0]      pp_s;
    logic [2*WORD_BITS-1:0]    shifted;

    eight_bit_adder u_adder (
        .A        (acc_q),
        .B        (m_q),
        .CarryIN  (1'b0),
        .CarryOUT (add_c),
        .Sum      (add_s)
    );

    // The adder carry becomes the 9th bit, shifted into acc[7], so nothing is lost.
    assign pp_c    = q_q[0] ? add_c : 1'b0;
    assign pp_s    = q_q[0] ? add_s : acc_q;
    assign shifted = {pp_c, pp_s, q_q[WORD_BITS-1:1]};

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    m_d     = A;
                    q_d     = B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                {acc_d, q_d} = shifted;
                cnt_d        = cnt_q + 3'd1;
                if (cnt_q == 3'(MUL_ITERS - 1)) begin
                    prod_d  = shifted;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Product = prod_q;

endmodule

// File: tb/tb_eight_bit_multiplier.sv
// Self-checking bench for eight_bit_multiplier: vector table plus scoreboard of expected products.
module tb_eight_bit_multiplier;

    logic        Clock;
    logic        ResetN;
    logic        Start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        Busy;
    logic        Done;
    logic [15:0] Product;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    eight_bit_multiplier u_dut (
        .Clock   (Clock),
        .ResetN  (ResetN),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every Done pops one expected product.
    always @(negedge Clock) begin
        if (ResetN === 1'b1) begin
            if (Busy && Done)
                check("busy_done_exclusive", {Busy, Done}, 2'b10);
            if (Done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(Done), 32'd0);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("product", 32'(Product), 32'(e));
                end
            end
        end
    end

    task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp);
        int busy_cycles;
        @(negedge Clock);
        A = a; B = b; Start = 1'b1;
        exp_q.push_back(exp);
        @(negedge Clock);
        Start = 1'b0;
        busy_cycles = 0;
        while (Busy && busy_cycles < 20) begin
            busy_cycles++;
            @(negedge Clock);
        end
        check({name, "_busy_cycles"}, 32'(busy_cycles), 32'd8);
        check({name, "_done"}, 32'(Done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int busy;
        logic [7:0] ra, rb;

        vecs[0] = '{8'd13,  8'd11,  16'h008F};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{8'd0,   8'd200, 16'h0000};
        vecs[3] = '{8'd1,   8'd128, 16'h0080};
        vecs[4] = '{8'd170, 8'd85,  16'h3872};
        vecs[5] = '{8'd128, 8'd255, 16'h7F80};

        Start = 1'b0; A = '0; B = '0; ResetN = 1'b1;
        #1 ResetN = 1'b0;
        repeat (3) @(negedge Clock);
        check("rst_product", 32'(Product), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        ResetN = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge Clock);
            if (Done || Busy) n++;
        end
        check("idle_no_activity", 32'(n), 32'd0);

        for (int i = 0; i < 6; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op($sformatf("rand%0d", i), ra, rb, 16'(ra) * 16'(rb));
        end

        // Back-to-back: restart in the DONE cycle.
        @(negedge Clock);
        A = 8'd6; B = 8'd7; Start = 1'b1;
        exp_q.push_back(16'd42);
        @(negedge Clock);
        Start = 1'b0;
        n = 0;
        while (!Done && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check("b2b_first_done", 32'(Done), 32'd1);
        A = 8'd2; B = 8'd3; Start = 1'b1;
        exp_q.push_back(16'd6);
        @(negedge Clock);
        Start = 1'b0;
        busy = 0;
        while (Busy && busy < 20) begin
            check("b2b_hold_42", 32'(Product), 32'd42);
            busy++;
            @(negedge Clock);
        end
        check("b2b_busy_cycles", 32'(busy), 32'd8);
        check("b2b_second_done", 32'(Done), 32'd1);

        // Start during RUN must be ignored.
        @(negedge Clock);
        A = 8'd5; B = 8'd5; Start = 1'b1;
        exp_q.push_back(16'd25);
        @(negedge Clock);
        Start = 1'b0;
        busy = 0;
        while (Busy && busy < 20) begin
            busy++;
            if (busy == 4) begin
                A = 8'd9; B = 8'd9; Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            @(negedge Clock);
        end
        Start = 1'b0;
        check("ign_busy_cycles", 32'(busy), 32'd8);
        check("ign_done", 32'(Done), 32'd1);
        n = 0;
        repeat (12) begin
            @(negedge Clock);
            if (Busy) n++;
        end
        check("ign_no_extra_busy", 32'(n), 32'd0);

        // Asynchronous reset in the middle of iteration 5.
        @(negedge Clock);
        A = 8'd100; B = 8'd100; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (4) @(negedge Clock);
        #2 ResetN = 1'b0;
        #1;
        check("midrst_product", 32'(Product), 32'd0);
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_done", 32'(Done), 32'd0);
        check("midrst_state", 32'(u_dut.state_q), 32'd0);
        repeat (2) @(negedge Clock);
        ResetN = 1'b1;
        do_op("post_rst", 8'd3, 8'd4, 16'd12);

        repeat (3) @(negedge Clock);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
